// File: rtl/osd_nasti_master.sv
// osd_nasti_master: turns a single-outstanding req/ack request from a debug
// module into one NASTI (AXI-lite) read or write transaction at a time.
// Optional response timeout with drain: define OSD_NASTI_MASTER_TIMEOUT_EN.
module osd_nasti_master #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TXN_ID     = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bus_req,
  input  logic                    bus_write,
  input  logic [ADDR_WIDTH-1:0]   bus_addr,
  input  logic [DATA_WIDTH-1:0]   bus_wdata,
  input  logic [DATA_WIDTH/8-1:0] bus_strb,
  output logic                    bus_ack,
  output logic [DATA_WIDTH-1:0]   bus_rdata,
  output logic                    bus_err,
  output logic [ID_WIDTH-1:0]     aw_id,
  output logic [ADDR_WIDTH-1:0]   aw_addr,
  output logic                    aw_valid,
  input  logic                    aw_ready,
  output logic [DATA_WIDTH-1:0]   w_data,
  output logic [DATA_WIDTH/8-1:0] w_strb,
  output logic                    w_valid,
  input  logic                    w_ready,
  input  logic [ID_WIDTH-1:0]     b_id,
  input  logic [1:0]              b_resp,
  input  logic                    b_valid,
  output logic                    b_ready,
  output logic [ID_WIDTH-1:0]     ar_id,
  output logic [ADDR_WIDTH-1:0]   ar_addr,
  output logic                    ar_valid,
  input  logic                    ar_ready,
  input  logic [ID_WIDTH-1:0]     r_id,
  input  logic [DATA_WIDTH-1:0]   r_data,
  input  logic [1:0]              r_resp,
  input  logic                    r_valid,
  output logic                    r_ready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_ACK
`ifdef OSD_NASTI_MASTER_TIMEOUT_EN
    , S_DRAIN
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   strb_q, strb_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    aw_valid_q, aw_valid_d;
  logic                    w_valid_q, w_valid_d;
  logic                    ar_valid_q, ar_valid_d;
  logic                    b_ready_q, b_ready_d;
  logic                    r_ready_q, r_ready_d;

`ifdef OSD_NASTI_MASTER_TIMEOUT_EN
  logic [31:0]             cnt_q, cnt_d;
  logic                    expired;
  assign expired = (cnt_q == 32'(TIMEOUT - 1));
`endif

  // IDs are fixed; b_id/r_id carry nothing useful with one transaction in flight
  logic unused_inputs;
`ifdef OSD_NASTI_MASTER_TIMEOUT_EN
  assign unused_inputs = ^{b_id, r_id};
`else
  assign unused_inputs = (^{b_id, r_id}) ^ (TIMEOUT != 0);
`endif

  // Next-state and next-output computation; all outputs are registered
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    ar_valid_d = ar_valid_q;
    b_ready_d  = b_ready_q;
    r_ready_d  = r_ready_q;
`ifdef OSD_NASTI_MASTER_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus_req) begin
          addr_d  = bus_addr;
          wdata_d = bus_wdata;
          strb_d  = bus_strb;
          write_d = bus_write;
          if (bus_write) begin
            state_d    = S_WADDR;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
          end else begin
            state_d    = S_RADDR;
            ar_valid_d = 1'b1;
          end
        end
      end
      S_WADDR: begin
        // AW and W retire independently; leave once both are gone
        aw_valid_d = aw_valid_q & ~aw_ready;
        w_valid_d  = w_valid_q & ~w_ready;
        if (!aw_valid_d && !w_valid_d) begin
          state_d   = S_WRESP;
          b_ready_d = 1'b1;
`ifdef OSD_NASTI_MASTER_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      S_WRESP: begin
        if (b_valid) begin
          state_d   = S_ACK;
          b_ready_d = 1'b0;
          ack_d     = 1'b1;
          err_d     = (b_resp != 2'b00);
        end
`ifdef OSD_NASTI_MASTER_TIMEOUT_EN
        else if (expired) begin
          state_d = S_DRAIN;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      S_RADDR: begin
        if (ar_ready) begin
          state_d    = S_RDATA;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
`ifdef OSD_NASTI_MASTER_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      S_RDATA: begin
        if (r_valid) begin
          state_d   = S_ACK;
          r_ready_d = 1'b0;
          rdata_d   = r_data;
          ack_d     = 1'b1;
          err_d     = (r_resp != 2'b00);
        end
`ifdef OSD_NASTI_MASTER_TIMEOUT_EN
        else if (expired) begin
          state_d = S_DRAIN;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
`ifdef OSD_NASTI_MASTER_TIMEOUT_EN
      S_DRAIN: begin
        // Swallow the late response silently; the requester was already answered
        if (write_q ? b_valid : r_valid) begin
          state_d   = S_IDLE;
          b_ready_d = 1'b0;
          r_ready_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      write_q    <= 1'b0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
`ifdef OSD_NASTI_MASTER_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      write_q    <= write_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      b_ready_q  <= b_ready_d;
      r_ready_q  <= r_ready_d;
`ifdef OSD_NASTI_MASTER_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus_ack   = ack_q;
  assign bus_err   = err_q;
  assign bus_rdata = rdata_q;
  assign aw_id     = ID_WIDTH'(TXN_ID);
  assign ar_id     = ID_WIDTH'(TXN_ID);
  assign aw_addr   = addr_q;
  assign ar_addr   = addr_q;
  assign w_data    = wdata_q;
  assign w_strb    = strb_q;
  assign aw_valid  = aw_valid_q;
  assign w_valid   = w_valid_q;
  assign ar_valid  = ar_valid_q;
  assign b_ready   = b_ready_q;
  assign r_ready   = r_ready_q;

endmodule

// File: tb/tb_osd_nasti_master.sv
// Self-checking bench for osd_nasti_master with a delay-configurable slave
// model and a scoreboard of expected completions.
module tb_osd_nasti_master;

`ifdef OSD_NASTI_MASTER_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_req = 1'b0;
  logic        bus_write = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [3:0]  bus_strb = '0;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic [0:0]  aw_id, ar_id;
  logic [31:0] aw_addr, ar_addr, w_data;
  logic [3:0]  w_strb;
  logic        aw_valid, aw_ready, w_valid, w_ready;
  logic        ar_valid, ar_ready, b_valid, b_ready, r_valid, r_ready;
  logic [1:0]  b_resp, r_resp;
  logic [31:0] r_data;

  // slave configuration (cycles of wait before ready/valid)
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = '0;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;

  // monitors
  int          cyc = 0, ack_cnt = 0;
  int          aw_hs = 0, w_hs = 0, ar_hs = 0;
  int          aw_vcyc = 0, w_vcyc = 0, ar_vcyc = 0, withdraw = 0;
  logic [31:0] mon_aw_addr = '0, mon_w_data = '0, mon_ar_addr = '0;
  logic [3:0]  mon_w_strb = '0;
  logic        p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;

  int checks = 0, errors = 0;
  logic [31:0] last_rd = '0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  osd_nasti_master #(
    .ID_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TXN_ID(0), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst_n),
    .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_strb(bus_strb),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(1'b0), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(1'b0), .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  always #5 clk = ~clk;

  assign aw_ready = aw_valid && (aw_cnt >= aw_dly);
  assign w_ready  = w_valid  && (w_cnt  >= w_dly);
  assign ar_ready = ar_valid && (ar_cnt >= ar_dly);
  assign b_valid  = b_ready  && (b_cnt  >= b_dly);
  assign r_valid  = r_ready  && (r_cnt  >= r_dly);
  assign b_resp   = b_resp_cfg;
  assign r_resp   = r_resp_cfg;
  assign r_data   = r_data_cfg;

  // slave wait counters
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
    end else begin
      aw_cnt <= (aw_valid && !aw_ready) ? aw_cnt + 1 : 0;
      w_cnt  <= (w_valid  && !w_ready)  ? w_cnt + 1  : 0;
      ar_cnt <= (ar_valid && !ar_ready) ? ar_cnt + 1 : 0;
      b_cnt  <= (b_ready  && !b_valid)  ? b_cnt + 1  : 0;
      r_cnt  <= (r_ready  && !r_valid)  ? r_cnt + 1  : 0;
    end
  end

  // handshake monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (aw_valid) aw_vcyc <= aw_vcyc + 1;
    if (w_valid)  w_vcyc  <= w_vcyc + 1;
    if (ar_valid) ar_vcyc <= ar_vcyc + 1;
    if (aw_valid && aw_ready) begin aw_hs <= aw_hs + 1; mon_aw_addr <= aw_addr; end
    if (w_valid && w_ready) begin w_hs <= w_hs + 1; mon_w_data <= w_data; mon_w_strb <= w_strb; end
    if (ar_valid && ar_ready) begin ar_hs <= ar_hs + 1; mon_ar_addr <= ar_addr; end
    if (rst_n && ((p_awv && !p_awr && !aw_valid) || (p_wv && !p_wr && !w_valid) ||
                  (p_arv && !p_arr && !ar_valid)))
      withdraw <= withdraw + 1;
    p_awv <= aw_valid; p_awr <= aw_ready; p_wv <= w_valid; p_wr <= w_ready;
    p_arv <= ar_valid; p_arr <= ar_ready;
  end

  always @(negedge clk) if (bus_ack) ack_cnt <= ack_cnt + 1;

  // Caller is at a negedge; returns at the negedge one cycle after bus_ack.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp_rd, input logic exp_err,
                        output int lat);
    exp_t e;
    int   c0;
    bit   got;
    bus_req = 1'b1; bus_write = wr; bus_addr = addr; bus_wdata = wdata; bus_strb = strb;
    sb.push_back('{rdata: exp_rd, err: exp_err});
    c0 = cyc; got = 1'b0; lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus_ack) begin got = 1'b1; break; end
    end
    bus_req = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_wait addr=%h: no bus_ack within budget, required one", addr);
    end else begin
      lat = cyc - c0;
      checks++;
      if (bus_rdata !== e.rdata) begin
        errors++;
        $display("FAIL rdata addr=%h: got %h expected %h", addr, bus_rdata, e.rdata);
      end
      checks++;
      if (bus_err !== e.err) begin
        errors++;
        $display("FAIL err addr=%h: got %b expected %b", addr, bus_err, e.err);
      end
      @(negedge clk);
      checks++;
      if (bus_ack !== 1'b0 || bus_err !== 1'b0) begin
        errors++;
        $display("FAIL ack_width addr=%h: ack=%b err=%b one cycle later, expected 0 0", addr, bus_ack, bus_err);
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, bus_ack, bus_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {aw_valid, w_valid, ar_valid, b_ready, r_ready, bus_ack, bus_err});
    end
    checks++;
    if ({bus_rdata, aw_addr, w_data, w_strb} !== '0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h strb=%h expected all 0",
               bus_rdata, aw_addr, w_data, w_strb);
    end
  endtask

  task automatic test_write_zero_wait;
    int lat, aw0, w0, ar0, awv0;
    aw_dly = 0; w_dly = 0; b_dly = 0; b_resp_cfg = 2'b00;
    aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs; awv0 = aw_vcyc;
    do_txn(1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF, last_rd, 1'b0, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    checks++;
    if (aw_hs - aw0 != 1 || w_hs - w0 != 1 || ar_hs - ar0 != 0) begin
      errors++;
      $display("FAIL wr_beats: aw=%0d w=%0d ar=%0d expected 1 1 0", aw_hs - aw0, w_hs - w0, ar_hs - ar0);
    end
    checks++;
    if (aw_vcyc - awv0 != 1) begin
      errors++; $display("FAIL wr_awvalid_len: got %0d expected 1", aw_vcyc - awv0);
    end
    checks++;
    if (mon_aw_addr !== 32'h1000 || mon_w_data !== 32'hA5A5A5A5 || mon_w_strb !== 4'hF) begin
      errors++;
      $display("FAIL wr_payload: addr=%h data=%h strb=%h expected 00001000 a5a5a5a5 f",
               mon_aw_addr, mon_w_data, mon_w_strb);
    end
  endtask

  task automatic test_read_delay;
    int lat, arv0;
    ar_dly = 2; r_dly = 5; r_data_cfg = 32'hDEADBEEF; r_resp_cfg = 2'b00;
    arv0 = ar_vcyc;
    do_txn(1'b0, 32'h2000, '0, '0, 32'hDEADBEEF, 1'b0, lat);
    last_rd = 32'hDEADBEEF;
    checks++;
    if (lat !== 10) begin errors++; $display("FAIL rd_latency: got %0d expected 10", lat); end
    checks++;
    if (ar_vcyc - arv0 != 3 || mon_ar_addr !== 32'h2000) begin
      errors++;
      $display("FAIL rd_arvalid: held %0d addr %h expected 3 00002000", ar_vcyc - arv0, mon_ar_addr);
    end
    ar_dly = 0; r_dly = 0;
  endtask

  task automatic test_write_late_aw;
    int lat, aw0, w0, awv0, wv0;
    aw_dly = 3; w_dly = 0; b_dly = 0; b_resp_cfg = 2'b10;
    aw0 = aw_hs; w0 = w_hs; awv0 = aw_vcyc; wv0 = w_vcyc;
    do_txn(1'b1, 32'h1004, 32'h0BADF00D, 4'h3, last_rd, 1'b1, lat);
    checks++;
    if (aw_vcyc - awv0 != 4 || w_vcyc - wv0 != 1) begin
      errors++;
      $display("FAIL late_aw_valid_len: aw=%0d w=%0d expected 4 1", aw_vcyc - awv0, w_vcyc - wv0);
    end
    checks++;
    if (aw_hs - aw0 != 1 || w_hs - w0 != 1) begin
      errors++; $display("FAIL late_aw_beats: aw=%0d w=%0d expected 1 1", aw_hs - aw0, w_hs - w0);
    end
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL late_aw_latency: got %0d expected 6", lat); end
    aw_dly = 0; b_resp_cfg = 2'b00;
  endtask

  task automatic test_back_to_back;
    int lat, a0, ar0;
    a0 = ack_cnt; ar0 = ar_hs;
    r_data_cfg = 32'h12345678; r_resp_cfg = 2'b00;
    do_txn(1'b0, 32'h2004, '0, '0, 32'h12345678, 1'b0, lat);
    last_rd = 32'h12345678;
    do_txn(1'b1, 32'h1008, 32'h55AA55AA, 4'h1, last_rd, 1'b0, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL b2b_latency: got %0d expected 3", lat); end
    r_data_cfg = 32'hCAFEF00D; r_resp_cfg = 2'b11;
    do_txn(1'b0, 32'h200C, '0, '0, 32'hCAFEF00D, 1'b1, lat);
    last_rd = 32'hCAFEF00D; r_resp_cfg = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if (ack_cnt - a0 != 3 || ar_hs - ar0 != 2) begin
      errors++;
      $display("FAIL b2b_counts: acks=%0d ar=%0d expected 3 2", ack_cnt - a0, ar_hs - ar0);
    end
  endtask

  task automatic test_reset_mid;
    int a0, lat;
    bit seen;
    r_dly = 20; seen = 1'b0;
    bus_req = 1'b1; bus_write = 1'b0; bus_addr = 32'h3000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r_ready) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_mid_reach: r_ready never rose, required 1"); end
    a0 = ack_cnt;
    #2 rst_n = 1'b0; bus_req = 1'b0;
    #1;
    checks++;
    if ({r_ready, bus_ack, ar_valid, bus_err} !== 4'b0 || bus_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_async: rready=%b ack=%b arvalid=%b err=%b rdata=%h expected 0",
               r_ready, bus_ack, ar_valid, bus_err, bus_rdata);
    end
    last_rd = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ack_cnt != a0) begin errors++; $display("FAIL rst_mid_noack: acks=%0d expected 0", ack_cnt - a0); end
    r_dly = 1; r_data_cfg = 32'h600DD00D;
    do_txn(1'b0, 32'h3004, '0, '0, 32'h600DD00D, 1'b0, lat);
    last_rd = 32'h600DD00D;
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL rst_mid_after: latency %0d expected 4", lat); end
    r_dly = 0;
  endtask

`ifdef OSD_NASTI_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    int lat, a0, ar0;
    b_dly = 40; b_resp_cfg = 2'b00; a0 = ack_cnt;
    do_txn(1'b1, 32'h1100, 32'h11112222, 4'hF, last_rd, 1'b1, lat);
    checks++;
    if (lat !== 18) begin errors++; $display("FAIL timeout_latency: got %0d expected 18", lat); end
    ar0 = ar_hs; r_data_cfg = 32'h77778888;
    do_txn(1'b0, 32'h2100, '0, '0, 32'h77778888, 1'b0, lat);
    last_rd = 32'h77778888;
    checks++;
    if (ack_cnt - a0 != 2 || ar_hs - ar0 != 1) begin
      errors++;
      $display("FAIL timeout_drain: acks=%0d ar=%0d expected 2 1", ack_cnt - a0, ar_hs - ar0);
    end
    b_dly = 0;
  endtask
`endif

  initial begin
    #1;
    test_reset;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_write_zero_wait;
    test_read_delay;
    test_write_late_aw;
    test_back_to_back;
    test_reset_mid;
`ifdef OSD_NASTI_MASTER_TIMEOUT_EN
    test_timeout;
`endif
    checks++;
    if (withdraw != 0) begin
      errors++; $display("FAIL valid_withdrawn: got %0d events expected 0", withdraw);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
